framed_tx1101: RTL and testbench

- Serial frame transmitter that produces the bit stream a 1101 sequence detector consumes.
- Accepts a parallel word through a valid/ready handshake.
- Emits the fixed sync pattern 1,1,0,1 followed by the payload MSB-first. Inserts stuff zeros so that 1101 never appears outside the sync pattern.
- Sits in front of the serial link, opposite the receive-side 1101 detector.

---
 rtl/tx1101_pkg.sv | 17 +
 rtl/tx1101_stuff_ctl.sv | 33 +++
 rtl/framed_tx1101.sv | 150 +++++++++++++++
 tb/tb_framed_tx1101.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx1101_pkg.sv
// Shared definitions for the framed 1101 serial transmitter.
//   t_enum_tx1101 : transmitter FSM state (2-bit encoding)
//   PREAMBLE      : sync pattern sent at the start of every frame
//   STUFF_TRIG    : bit history that would let the next 1 complete a 1101
package tx1101_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      PAY  = 2'd2,
      GAP  = 2'd3
   } t_enum_tx1101;

   localparam logic [3:0] PREAMBLE   = 4'b1101;
   localparam logic [2:0] STUFF_TRIG = 3'b110;

endpackage

// File: rtl/tx1101_stuff_ctl.sv
// Stuff-bit controller: tracks the last three bits placed on the line and
// requests a stuff zero whenever they read 110, since a following 1 would
// otherwise recreate the sync pattern inside the payload.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : clear history at frame start
//   bit_vld    : a line bit is emitted this cycle
//   bit_val    : value of that emitted bit
//   stuff_req  : history equals 110, next bit must be a stuff zero
module tx1101_stuff_ctl
   import tx1101_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic bit_vld,
   input  logic bit_val,
   output logic stuff_req
);

   logic [2:0] hist;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         hist <= 3'b000;
      end else if (bit_vld) begin
         hist <= {hist[1:0], bit_val};
      end
   end

   assign stuff_req = (hist == STUFF_TRIG);

endmodule

// File: rtl/framed_tx1101.sv
// Framed serial transmitter feeding a 1101 sequence detector.
// A word accepted over valid/ready is sent as the sync pattern 1101, then
// the payload MSB-first with stuff zeros so 1101 never appears outside the
// sync pattern, then GAP_BITS forced zeros.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_data     : payload word, taken when in_valid && in_ready
//   in_valid    : upstream word available
//   in_ready    : high only while idle (combinational from state)
//   out_bit     : registered serial line bit
//   tx_active   : registered, line carries preamble/payload/stuff
//   stuff_flag  : registered, current line bit is a stuff zero
//   frame_done  : registered one-cycle pulse on the last gap bit
module framed_tx1101
   import tx1101_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int GAP_BITS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_bit,
   output logic              tx_active,
   output logic              stuff_flag,
   output logic              frame_done
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int GAP_W = $clog2(GAP_BITS + 1);

   t_enum_tx1101      state, state_nxt;
   logic [1:0]        pre_idx, pre_idx_nxt;
   logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
   logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
   logic [DATA_W-1:0] shreg;

   logic out_bit_nxt, tx_active_nxt, stuff_flag_nxt, frame_done_nxt;
   logic load, shift, emit, hist_clr, stuff_req;

   tx1101_stuff_ctl u_stuff (
      .clk       (clk),
      .rst       (rst),
      .clr       (hist_clr),
      .bit_vld   (emit),
      .bit_val   (out_bit_nxt),
      .stuff_req (stuff_req)
   );

   // State and registered line outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pre_idx    <= 2'd0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         out_bit    <= 1'b0;
         tx_active  <= 1'b0;
         stuff_flag <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         pre_idx    <= pre_idx_nxt;
         bit_cnt    <= bit_cnt_nxt;
         gap_cnt    <= gap_cnt_nxt;
         out_bit    <= out_bit_nxt;
         tx_active  <= tx_active_nxt;
         stuff_flag <= stuff_flag_nxt;
         frame_done <= frame_done_nxt;
      end
   end

   // Payload shift register is pure data and carries no reset
   always_ff @(posedge clk) begin
      if (load) begin
         shreg <= in_data;
      end else if (shift) begin
         shreg <= shreg << 1;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt      = state;
      pre_idx_nxt    = pre_idx;
      bit_cnt_nxt    = bit_cnt;
      gap_cnt_nxt    = gap_cnt;
      out_bit_nxt    = 1'b0;
      tx_active_nxt  = 1'b0;
      stuff_flag_nxt = 1'b0;
      frame_done_nxt = 1'b0;
      load           = 1'b0;
      shift          = 1'b0;
      emit           = 1'b0;
      hist_clr       = 1'b0;
      in_ready       = 1'b0;

      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load        = 1'b1;
               hist_clr    = 1'b1;
               pre_idx_nxt = 2'd0;
               bit_cnt_nxt = '0;
               gap_cnt_nxt = '0;
               state_nxt   = PRE;
            end
         end
         PRE: begin
            out_bit_nxt   = PREAMBLE[2'd3 - pre_idx];
            tx_active_nxt = 1'b1;
            emit          = 1'b1;
            pre_idx_nxt   = pre_idx + 2'd1;
            if (pre_idx == 2'd3) begin
               state_nxt = PAY;
            end
         end
         PAY: begin
            tx_active_nxt = 1'b1;
            emit          = 1'b1;
            // The state leaves PAY on the last payload bit, so being here
            // guarantees at least one payload bit is still pending.
            if (stuff_req) begin
               stuff_flag_nxt = 1'b1;
            end else begin
               out_bit_nxt = shreg[DATA_W-1];
               shift       = 1'b1;
               bit_cnt_nxt = bit_cnt + 1'b1;
               if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                  state_nxt = GAP;
               end
            end
         end
         GAP: begin
            gap_cnt_nxt = gap_cnt + 1'b1;
            if (gap_cnt == GAP_W'(GAP_BITS - 1)) begin
               frame_done_nxt = 1'b1;
               state_nxt      = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_framed_tx1101.sv
// Bench for framed_tx1101: reference model builds the expected line stream
// (sync pattern, payload with zero stuffing after any 110, gap) per frame.
module tb_framed_tx1101;

   localparam int DATA_W   = 8;
   localparam int GAP_BITS = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              out_bit;
   logic              tx_active;
   logic              stuff_flag;
   logic              frame_done;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   // Per-cycle vectors {in_ready, out_bit, tx_active, stuff_flag, frame_done}
   logic [4:0] obs[$];
   logic [4:0] exp_q[$];
   bit         stream[$];
   int         pre_pos[$];

   always #5 clk = ~clk;

   framed_tx1101 #(.DATA_W(DATA_W), .GAP_BITS(GAP_BITS)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_bit    (out_bit),
      .tx_active  (tx_active),
      .stuff_flag (stuff_flag),
      .frame_done (frame_done)
   );

   function automatic logic [4:0] obs_vec();
      return {in_ready, out_bit, tx_active, stuff_flag, frame_done};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected samples from the accept edge onward: one idle zero, sync
   // pattern, payload with stuffing, then the gap ending back in idle.
   task automatic build_model(input logic [DATA_W-1:0] d);
      logic [3:0] pre;
      bit         line[$];
      int         idx;
      pre = 4'b1101;
      exp_q.delete();
      exp_q.push_back(5'b00000);
      for (int i = 0; i < 4; i++) begin
         line.push_back(pre[3-i]);
         exp_q.push_back({1'b0, pre[3-i], 1'b1, 1'b0, 1'b0});
      end
      idx = DATA_W - 1;
      while (idx >= 0) begin
         int n;
         n = line.size();
         if (line[n-3] == 1'b1 && line[n-2] == 1'b1 && line[n-1] == 1'b0) begin
            line.push_back(1'b0);
            exp_q.push_back(5'b00110);
         end else begin
            line.push_back(d[idx]);
            exp_q.push_back({1'b0, d[idx], 1'b1, 1'b0, 1'b0});
            idx--;
         end
      end
      for (int g = 0; g < GAP_BITS; g++) begin
         exp_q.push_back({(g == GAP_BITS - 1), 3'b000, (g == GAP_BITS - 1)});
      end
   endtask

   // Offers a word, then records n samples starting at the accept edge.
   task automatic capture(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] nxt,
                          input bit keep, input int n, output logic rdy);
      in_data  = d;
      in_valid = 1'b1;
      rdy      = in_ready;
      obs.delete();
      pre_pos.push_back(stream.size() + 1);
      for (int i = 0; i < n; i++) begin
         tick();
         if (i == 0) begin
            in_data  = nxt;
            in_valid = keep;
         end
         obs.push_back(obs_vec());
         stream.push_back(out_bit);
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = DATA_W'($urandom);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_cnt++;
         if (obs_vec() !== 5'b10000)
            $display("FAIL reset_hold cyc %0d got %b want %b", i, obs_vec(), 5'b10000);
         else pass_cnt++;
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      chk_cnt++;
      if (in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (obs_vec() !== 5'b10000)
         $display("FAIL reset_no_accept got %b want %b", obs_vec(), 5'b10000);
      else pass_cnt++;
   endtask

   task automatic test_fixed(input logic [DATA_W-1:0] d, input int act_want,
                             input int stf_want, input string name);
      logic rdy;
      int   act, stf;
      build_model(d);
      capture(d, DATA_W'($urandom), 1'b0, exp_q.size(), rdy);
      chk_cnt++;
      if (rdy !== 1'b1) $display("FAIL %s ready_before got %b want 1", name, rdy);
      else pass_cnt++;
      act = 0;
      stf = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         act += int'(obs[i][2]);
         stf += int'(obs[i][1]);
         chk_cnt++;
         if (obs[i] !== exp_q[i])
            $display("FAIL %s cyc %0d got %b want %b", name, i, obs[i], exp_q[i]);
         else pass_cnt++;
      end
      chk_cnt++;
      if (act != act_want) $display("FAIL %s active_count got %0d want %0d", name, act, act_want);
      else pass_cnt++;
      chk_cnt++;
      if (stf != stf_want) $display("FAIL %s stuff_count got %0d want %0d", name, stf, stf_want);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic rdy;
      int   hits;
      bit   ok;
      stream.delete();
      pre_pos.delete();
      build_model(8'hFF);
      capture(8'hFF, 8'h0F, 1'b1, exp_q.size(), rdy);
      for (int i = 0; i < exp_q.size(); i++) begin
         chk_cnt++;
         if (obs[i] !== exp_q[i])
            $display("FAIL b2b_first cyc %0d got %b want %b", i, obs[i], exp_q[i]);
         else pass_cnt++;
      end
      build_model(8'h0F);
      capture(8'h0F, DATA_W'($urandom), 1'b0, exp_q.size(), rdy);
      chk_cnt++;
      if (rdy !== 1'b1) $display("FAIL b2b_ready got %b want 1", rdy);
      else pass_cnt++;
      for (int i = 0; i < exp_q.size(); i++) begin
         chk_cnt++;
         if (obs[i] !== exp_q[i])
            $display("FAIL b2b_second cyc %0d got %b want %b", i, obs[i], exp_q[i]);
         else pass_cnt++;
      end
      hits = 0;
      for (int i = 0; i + 3 < stream.size(); i++) begin
         if (stream[i] && stream[i+1] && !stream[i+2] && stream[i+3]) begin
            hits++;
            ok = 1'b0;
            foreach (pre_pos[k]) if (pre_pos[k] == i) ok = 1'b1;
            chk_cnt++;
            if (!ok) $display("FAIL b2b_scan 1101 at bit %0d got payload hit want preamble only", i);
            else pass_cnt++;
         end
      end
      chk_cnt++;
      if (hits != pre_pos.size())
         $display("FAIL b2b_scan_count got %0d want %0d", hits, pre_pos.size());
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic              rdy;
      logic [DATA_W-1:0] d;
      bit                keep;
      int                hits;
      bit                ok;
      stream.delete();
      pre_pos.delete();
      for (int f = 0; f < 10; f++) begin
         d    = DATA_W'($urandom);
         keep = (f < 9) ? bit'($urandom_range(0, 1)) : 1'b0;
         build_model(d);
         capture(d, DATA_W'($urandom), keep, exp_q.size(), rdy);
         chk_cnt++;
         if (rdy !== 1'b1) $display("FAIL rand_ready frame %0d got %b want 1", f, rdy);
         else pass_cnt++;
         for (int i = 0; i < exp_q.size(); i++) begin
            chk_cnt++;
            if (obs[i] !== exp_q[i])
               $display("FAIL rand frame %0d data %h cyc %0d got %b want %b", f, d, i, obs[i], exp_q[i]);
            else pass_cnt++;
         end
         if (!keep) begin
            repeat ($urandom_range(0, 3)) begin
               tick();
               stream.push_back(out_bit);
            end
         end
      end
      hits = 0;
      for (int i = 0; i + 3 < stream.size(); i++) begin
         if (stream[i] && stream[i+1] && !stream[i+2] && stream[i+3]) begin
            hits++;
            ok = 1'b0;
            foreach (pre_pos[k]) if (pre_pos[k] == i) ok = 1'b1;
            chk_cnt++;
            if (!ok) $display("FAIL rand_scan 1101 at bit %0d got payload hit want preamble only", i);
            else pass_cnt++;
         end
      end
      chk_cnt++;
      if (hits != pre_pos.size())
         $display("FAIL rand_scan_count got %0d want %0d", hits, pre_pos.size());
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_frame();
      logic rdy;
      build_model(8'hA5);
      // accept sample, four preamble bits, two payload bits
      capture(8'hA5, DATA_W'($urandom), 1'b0, 7, rdy);
      for (int i = 0; i < 7; i++) begin
         chk_cnt++;
         if (obs[i] !== exp_q[i])
            $display("FAIL midrst_pre cyc %0d got %b want %b", i, obs[i], exp_q[i]);
         else pass_cnt++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_cnt++;
      if (obs_vec() !== 5'b10000)
         $display("FAIL midrst_idle got %b want %b", obs_vec(), 5'b10000);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_cnt++;
         if (obs_vec() !== 5'b10000)
            $display("FAIL midrst_quiet cyc %0d got %b want %b", i, obs_vec(), 5'b10000);
         else pass_cnt++;
      end
      build_model(8'h3C);
      capture(8'h3C, DATA_W'($urandom), 1'b0, exp_q.size(), rdy);
      chk_cnt++;
      if (rdy !== 1'b1) $display("FAIL midrst_ready got %b want 1", rdy);
      else pass_cnt++;
      for (int i = 0; i < exp_q.size(); i++) begin
         chk_cnt++;
         if (obs[i] !== exp_q[i])
            $display("FAIL midrst_next cyc %0d got %b want %b", i, obs[i], exp_q[i]);
         else pass_cnt++;
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      test_reset();
      test_fixed(8'h00, 12, 0, "zero");
      test_fixed(8'hD0, 13, 1, "stuff_d0");
      test_fixed(8'h06, 12, 0, "tail_06");
      test_back_to_back();
      test_random();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
